// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the in-place radix-2 DIT FFT engine: sequencer FSM
// encoding and the default transform size / pipeline latency that the
// sequencer, butterfly and memory wrappers all agree on.
// -----------------------------------------------------------------------------
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fft_state_t;

    // log2 of the transform length (N = 32)
    localparam int FFT_LOG2N    = 5;
    // read-enable to write-enable latency: 1 RAM read cycle + 3 butterfly stages
    localparam int FFT_PIPE_LAT = 4;

    // Bits needed to hold the values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : fft_pkg

// File: rtl/fft_delay_line.sv
// -----------------------------------------------------------------------------
// fft_delay_line
// Plain register chain, W bits wide and D registers deep, with an
// asynchronous active-low clear. Used to carry {valid, addr_a, addr_b} from
// the read side of the butterfly to its write-back side.
//
// Ports:
//   clk    in  1   rising-edge clock
//   rst_n  in  1   asynchronous active-low clear of every tap
//   d      in  W   word entering the chain
//   q      out W   d delayed by exactly D clock cycles
// -----------------------------------------------------------------------------
module fft_delay_line #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < D; gi++) begin : g_tap
            logic [W-1:0] tap_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        tap_reg <= '0;
                    end else begin
                        tap_reg <= d;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        tap_reg <= '0;
                    end else begin
                        tap_reg <= g_tap[gi-1].tap_reg;
                    end
                end
            end
        end
    endgenerate

    assign q = g_tap[D-1].tap_reg;

endmodule : fft_delay_line

// File: rtl/fft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// fft_stage_sequencer
// Control and address generator for the in-place radix-2 DIT FFT. Each ISSUE
// cycle it presents one butterfly's read addresses and twiddle index; the same
// addresses re-emerge PIPE_LAT cycles later as write-back addresses. Between
// stages the pipeline is drained so the next stage never reads a location
// whose write is still in flight.
//
// Ports:
//   clk          in  1        rising-edge clock
//   rst_n        in  1        asynchronous active-low reset
//   i_start      in  1        start request (taken in IDLE, or held through DONE)
//   o_busy       out 1        high from first ISSUE cycle through DONE
//   o_done       out 1        one-cycle pulse after the last write-back issued
//   o_stage      out LOG2N    current stage index
//   o_rd_en      out 1        data-memory read strobe
//   o_rd_addr_a  out LOG2N    butterfly upper input address
//   o_rd_addr_b  out LOG2N    butterfly lower input address
//   o_tw_addr    out LOG2N-1  twiddle ROM index, aligned with o_rd_en
//   o_wr_en      out 1        o_rd_en delayed by PIPE_LAT
//   o_wr_addr_a  out LOG2N    o_rd_addr_a delayed by PIPE_LAT
//   o_wr_addr_b  out LOG2N    o_rd_addr_b delayed by PIPE_LAT
// -----------------------------------------------------------------------------
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N    = FFT_LOG2N,
    parameter int PIPE_LAT = FFT_PIPE_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic [LOG2N-1:0] o_stage,
    output logic             o_rd_en,
    output logic [LOG2N-1:0] o_rd_addr_a,
    output logic [LOG2N-1:0] o_rd_addr_b,
    output logic [LOG2N-2:0] o_tw_addr,
    output logic             o_wr_en,
    output logic [LOG2N-1:0] o_wr_addr_a,
    output logic [LOG2N-1:0] o_wr_addr_b
);

    localparam int HALF_N = 1 << (LOG2N - 1);
    localparam int DW     = cnt_width(PIPE_LAT);
    localparam int WB_W   = 1 + 2 * LOG2N;

    localparam logic [LOG2N-2:0] LAST_BFLY  = (LOG2N-1)'(HALF_N - 1);
    localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N-1:0] ONE_N      = LOG2N'(1);
    localparam logic [DW-1:0]    DRAIN_LOAD = DW'(PIPE_LAT);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(1);

    fft_state_t       state_reg, state_next;
    logic [LOG2N-1:0] stage_reg, stage_next;
    logic [LOG2N-2:0] bfly_reg,  bfly_next;
    logic [DW-1:0]    drain_reg, drain_next;

    // Output registers are loaded from the next-state values so that every
    // output is a flop yet lines up with the state it describes.
    logic             rd_en_reg;
    logic [LOG2N-1:0] rd_addr_a_reg, rd_addr_b_reg;
    logic [LOG2N-2:0] tw_addr_reg;
    logic             busy_reg, done_reg;

    // Address math for (stage_next, bfly_next)
    logic [LOG2N-2:0] pos_mask, pos_next, grp_next, tw_next;
    logic [LOG2N-1:0] span_next, addr_a_next, addr_b_next, tw_shamt;

    logic [WB_W-1:0]  wb_q;

    // -------------------------------------------------------------------------
    // Next-state / counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        bfly_next  = bfly_reg;
        drain_next = drain_reg;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    state_next = ISSUE;
                    stage_next = '0;
                    bfly_next  = '0;
                end
            end
            ISSUE: begin
                if (bfly_reg == LAST_BFLY) begin
                    state_next = DRAIN;
                    bfly_next  = '0;
                    drain_next = DRAIN_LOAD;
                end else begin
                    bfly_next = bfly_reg + 1'b1;
                end
            end
            DRAIN: begin
                // Counter runs PIPE_LAT..1, so DRAIN spans exactly PIPE_LAT cycles
                // and the next read lands one cycle after the last write-back.
                if (drain_reg == DRAIN_LAST) begin
                    drain_next = '0;
                    if (stage_reg == LAST_STAGE) begin
                        state_next = DONE;
                    end else begin
                        state_next = ISSUE;
                        stage_next = stage_reg + 1'b1;
                        bfly_next  = '0;
                    end
                end else begin
                    drain_next = drain_reg - 1'b1;
                end
            end
            DONE: begin
                // A start still asserted here chains straight into the next
                // transform, keeping back-to-back runs gap-free.
                if (i_start) begin
                    state_next = ISSUE;
                    stage_next = '0;
                    bfly_next  = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Butterfly addressing: span = 1<<s, pos = j mod span, grp = j / span,
    // a = grp*2*span + pos, b = a + span, tw = pos << (LOG2N-1-s).
    // pos < span and a has a zero at bit s, so OR replaces the additions.
    // -------------------------------------------------------------------------
    always_comb begin
        pos_mask    = ~({(LOG2N-1){1'b1}} << stage_next);
        pos_next    = bfly_next & pos_mask;
        grp_next    = bfly_next >> stage_next;
        span_next   = ONE_N << stage_next;
        addr_a_next = ({1'b0, grp_next} << (stage_next + 1'b1)) | {1'b0, pos_next};
        addr_b_next = addr_a_next | span_next;
        tw_shamt    = LAST_STAGE - stage_next;
        tw_next     = pos_next << tw_shamt;
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            stage_reg     <= '0;
            bfly_reg      <= '0;
            drain_reg     <= '0;
            rd_en_reg     <= 1'b0;
            rd_addr_a_reg <= '0;
            rd_addr_b_reg <= '0;
            tw_addr_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            stage_reg <= stage_next;
            bfly_reg  <= bfly_next;
            drain_reg <= drain_next;
            rd_en_reg <= (state_next == ISSUE);
            busy_reg  <= (state_next != IDLE);
            done_reg  <= (state_next == DONE);
            if (state_next == ISSUE) begin
                rd_addr_a_reg <= addr_a_next;
                rd_addr_b_reg <= addr_b_next;
                tw_addr_reg   <= tw_next;
            end else begin
                rd_addr_a_reg <= '0;
                rd_addr_b_reg <= '0;
                tw_addr_reg   <= '0;
            end
        end
    end

    // Write-back side: the read strobe and addresses shifted PIPE_LAT deep,
    // free-running so the last stage's writes finish while in DRAIN. Reset
    // clears the chain, so no partial writes leak out after an abort.
    fft_delay_line #(
        .W (WB_W),
        .D (PIPE_LAT)
    ) u_wb_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({rd_en_reg, rd_addr_a_reg, rd_addr_b_reg}),
        .q     (wb_q)
    );

    assign o_busy      = busy_reg;
    assign o_done      = done_reg;
    assign o_stage     = stage_reg;
    assign o_rd_en     = rd_en_reg;
    assign o_rd_addr_a = rd_addr_a_reg;
    assign o_rd_addr_b = rd_addr_b_reg;
    assign o_tw_addr   = tw_addr_reg;
    assign {o_wr_en, o_wr_addr_a, o_wr_addr_b} = wb_q;

endmodule : fft_stage_sequencer

// File: tb/tb_fft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft_stage_sequencer
// Two sequencers side by side: dut0 with LOG2N=3 (hand-tabulated addresses)
// and dut1 with the default LOG2N=5. Stimulus pushes expected reads, writes
// and done pulses (with their cycle numbers relative to the start edge) into
// queues; the negedge monitors pop and compare whenever a strobe appears.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_stage_sequencer;
    import fft_pkg::*;

    localparam int A_LOG2N = 3;
    localparam int B_LOG2N = FFT_LOG2N;
    localparam int LAT     = 4;

    typedef struct packed {
        int cyc;
        int a;
        int b;
        int tw;
        int st;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n0, rst_n1, start0, start1;

    logic                busy0, done0, rd_en0, wr_en0;
    logic [A_LOG2N-1:0]  stage0, ra0, rb0, wa0, wb0;
    logic [A_LOG2N-2:0]  tw0;

    logic                busy1, done1, rd_en1, wr_en1;
    logic [B_LOG2N-1:0]  stage1, ra1, rb1, wa1, wb1;
    logic [B_LOG2N-2:0]  tw1;

    fft_stage_sequencer #(.LOG2N(A_LOG2N), .PIPE_LAT(LAT)) dut0 (
        .clk(clk), .rst_n(rst_n0), .i_start(start0),
        .o_busy(busy0), .o_done(done0), .o_stage(stage0),
        .o_rd_en(rd_en0), .o_rd_addr_a(ra0), .o_rd_addr_b(rb0), .o_tw_addr(tw0),
        .o_wr_en(wr_en0), .o_wr_addr_a(wa0), .o_wr_addr_b(wb0)
    );

    fft_stage_sequencer #(.LOG2N(B_LOG2N), .PIPE_LAT(LAT)) dut1 (
        .clk(clk), .rst_n(rst_n1), .i_start(start1),
        .o_busy(busy1), .o_done(done1), .o_stage(stage1),
        .o_rd_en(rd_en1), .o_rd_addr_a(ra1), .o_rd_addr_b(rb1), .o_tw_addr(tw1),
        .o_wr_en(wr_en1), .o_wr_addr_a(wa1), .o_wr_addr_b(wb1)
    );

    exp_t rdq0[$], wrq0[$], rdq1[$], wrq1[$];
    int   dq0[$], dq1[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base0    = 0;
    int base1    = 0;

    // Hand-derived LOG2N=3 butterflies, in issue order (stage-major).
    int tab_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int tab_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int tab_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- checks
    task automatic check_rd(input int d, input int rel, input int a, input int b,
                            input int tw, input int st, input logic busy);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        e  = '0;
        if (d == 0 && rdq0.size() > 0) begin e = rdq0.pop_front(); ok = 1'b1; end
        if (d == 1 && rdq1.size() > 0) begin e = rdq1.pop_front(); ok = 1'b1; end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL dut%0d rd_unexpected got cyc=%0d a=%0d b=%0d tw=%0d st=%0d want no read", d, rel, a, b, tw, st);
        end else if (e.cyc != rel || e.a != a || e.b != b || e.tw != tw || e.st != st || busy !== 1'b1) begin
            failures++;
            $display("FAIL dut%0d rd got cyc=%0d a=%0d b=%0d tw=%0d st=%0d busy=%0b want cyc=%0d a=%0d b=%0d tw=%0d st=%0d busy=1",
                     d, rel, a, b, tw, st, busy, e.cyc, e.a, e.b, e.tw, e.st);
        end else begin
            $display("dut%0d rd  cyc=%0d a=%0d b=%0d tw=%0d st=%0d ok", d, rel, a, b, tw, st);
        end
    endtask

    task automatic check_wr(input int d, input int rel, input int a, input int b);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        e  = '0;
        if (d == 0 && wrq0.size() > 0) begin e = wrq0.pop_front(); ok = 1'b1; end
        if (d == 1 && wrq1.size() > 0) begin e = wrq1.pop_front(); ok = 1'b1; end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL dut%0d wr_unexpected got cyc=%0d a=%0d b=%0d want no write", d, rel, a, b);
        end else if (e.cyc != rel || e.a != a || e.b != b) begin
            failures++;
            $display("FAIL dut%0d wr got cyc=%0d a=%0d b=%0d want cyc=%0d a=%0d b=%0d", d, rel, a, b, e.cyc, e.a, e.b);
        end else begin
            $display("dut%0d wr  cyc=%0d a=%0d b=%0d ok", d, rel, a, b);
        end
    endtask

    task automatic check_done(input int d, input int rel, input logic busy);
        int  want;
        bit  ok;
        ok   = 1'b0;
        want = 0;
        if (d == 0 && dq0.size() > 0) begin want = dq0.pop_front(); ok = 1'b1; end
        if (d == 1 && dq1.size() > 0) begin want = dq1.pop_front(); ok = 1'b1; end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL dut%0d done_unexpected got cyc=%0d want no done", d, rel);
        end else if (want != rel || busy !== 1'b1) begin
            failures++;
            $display("FAIL dut%0d done got cyc=%0d busy=%0b want cyc=%0d busy=1", d, rel, busy, want);
        end else begin
            $display("dut%0d done cyc=%0d ok", d, rel);
        end
    endtask

    // Monitors: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rd_en0 === 1'b1) check_rd(0, cyc - base0 + 1, int'(ra0), int'(rb0), int'(tw0), int'(stage0), busy0);
        if (wr_en0 === 1'b1) check_wr(0, cyc - base0 + 1, int'(wa0), int'(wb0));
        if (done0  === 1'b1) check_done(0, cyc - base0 + 1, busy0);
        if (rd_en1 === 1'b1) check_rd(1, cyc - base1 + 1, int'(ra1), int'(rb1), int'(tw1), int'(stage1), busy1);
        if (wr_en1 === 1'b1) check_wr(1, cyc - base1 + 1, int'(wa1), int'(wb1));
        if (done1  === 1'b1) check_done(1, cyc - base1 + 1, busy1);
    end

    task automatic check_idle(input int d, input string tag);
        logic z;
        if (d == 0) z = busy0 | done0 | rd_en0 | wr_en0 | (|stage0) | (|ra0) | (|rb0) | (|tw0) | (|wa0) | (|wb0);
        else        z = busy1 | done1 | rd_en1 | wr_en1 | (|stage1) | (|ra1) | (|rb1) | (|tw1) | (|wa1) | (|wb1);
        checks++;
        if (z !== 1'b0) begin
            failures++;
            $display("FAIL dut%0d %s outputs_nonzero got any=%b want 0", d, tag, z);
        end else begin
            $display("dut%0d %s all outputs zero ok", d, tag);
        end
    endtask

    task automatic check_empty(input int d, input string tag);
        int nr, nw, nd;
        nr = (d == 0) ? rdq0.size() : rdq1.size();
        nw = (d == 0) ? wrq0.size() : wrq1.size();
        nd = (d == 0) ? dq0.size()  : dq1.size();
        checks++;
        if (nr != 0 || nw != 0 || nd != 0) begin
            failures++;
            $display("FAIL dut%0d %s missing_events got pending rd=%0d wr=%0d done=%0d want 0/0/0", d, tag, nr, nw, nd);
        end else begin
            $display("dut%0d %s all expected events seen ok", d, tag);
        end
    endtask

    // ------------------------------------------------------------ expectations
    // LOG2N=3: each stage is 4 reads + 4 drain cycles = 8; done in cycle 25.
    task automatic push_a(input int off, input int nrd, input int nwr, input bit with_done);
        exp_t e;
        for (int k = 0; k < 12; k++) begin
            e.cyc = off + 1 + 8 * (k / 4) + (k % 4);
            e.a   = tab_a[k];
            e.b   = tab_b[k];
            e.tw  = tab_tw[k];
            e.st  = k / 4;
            if (k < nrd) rdq0.push_back(e);
            e.cyc = e.cyc + LAT;
            if (k < nwr) wrq0.push_back(e);
        end
        if (with_done) dq0.push_back(off + 25);
    endtask

    // LOG2N=5: textbook group/position loop; 16 reads + 4 drain = 20 per stage.
    task automatic push_b(input int off);
        exp_t e;
        int   span;
        for (int s = 0; s < 5; s++) begin
            span = 1 << s;
            for (int g = 0; g < 16 / span; g++) begin
                for (int p = 0; p < span; p++) begin
                    e.cyc = off + 1 + 20 * s + g * span + p;
                    e.a   = g * 2 * span + p;
                    e.b   = e.a + span;
                    e.tw  = p * (16 / span);
                    e.st  = s;
                    rdq1.push_back(e);
                    e.cyc = e.cyc + LAT;
                    wrq1.push_back(e);
                end
            end
        end
        dq1.push_back(off + 101);
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;

        // Reset behaviour
        repeat (3) @(negedge clk);
        check_idle(0, "in_reset");
        check_idle(1, "in_reset");
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_idle(0, "post_reset");
            check_idle(1, "post_reset");
        end

        // dut0: one full LOG2N=3 transform
        @(negedge clk);
        base0 = cyc + 1;
        push_a(0, 12, 12, 1'b1);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (35) @(negedge clk);
        check_empty(0, "run_a");
        checks++;
        if (stage0 !== 3'd2 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL dut0 stage_hold got stage=%0d busy=%0b want stage=2 busy=0", stage0, busy0);
        end else begin
            $display("dut0 stage_hold stage=2 busy=0 ok");
        end

        // dut1: default transform, stray starts at cycles 10 and 50 ignored
        @(negedge clk);
        base1 = cyc + 1;
        push_b(0);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (9) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (39) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (60) @(negedge clk);
        check_empty(1, "run_b");

        // dut0: reset during stage 1 butterfly 2, then a clean rerun
        @(negedge clk);
        base0 = cyc + 1;
        push_a(0, 7, 4, 1'b0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n0 = 1'b0;
        #1 check_idle(0, "async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n0 = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (wr_en0 !== 1'b0) begin
                failures++;
                $display("FAIL dut0 post_abort_wr got wr_en=%b want 0", wr_en0);
            end else begin
                $display("dut0 post_abort no write ok");
            end
        end
        check_empty(0, "abort");
        @(negedge clk);
        base0 = cyc + 1;
        push_a(0, 12, 12, 1'b1);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (35) @(negedge clk);
        check_empty(0, "rerun_a");

        // dut1: start held high -> two transforms, done pulses 101 cycles apart
        @(negedge clk);
        base1 = cyc + 1;
        push_b(0);
        push_b(101);
        start1 = 1'b1;
        repeat (110) @(negedge clk);
        start1 = 1'b0;
        repeat (100) @(negedge clk);
        check_empty(1, "back_to_back");
        checks++;
        if (busy1 !== 1'b0) begin
            failures++;
            $display("FAIL dut1 idle_after_b2b got busy=%b want 0", busy1);
        end else begin
            $display("dut1 idle_after_b2b busy=0 ok");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fft_stage_sequencer
